// File: rtl/sized_data_memory.sv
// Byte/halfword/word addressable 32-bit data memory with registered responses,
// alignment checking and a self-clearing init sweep after every reset.
module sized_data_memory #(
   parameter  int unsigned ADDR_WIDTH      = 10,
   localparam int unsigned BYTE_ADDR_WIDTH = ADDR_WIDTH + 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [1:0]                 req_size,
   input  logic                       req_signed,
   input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       rsp_valid,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_err,
   output logic                       init_busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      INIT,
      IDLE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [31:0]           mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  accept;
   logic                  err;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_lane;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;

   assign word_idx = req_addr[BYTE_ADDR_WIDTH-1:2];
   assign lane     = req_addr[1:0];
   assign accept   = req_valid && (state == IDLE);

   always_comb begin
      state_next = state;
      init_busy  = 1'b0;
      req_ready  = 1'b0;
      case (state)
         INIT: begin
            init_busy = 1'b1;
            if (init_cnt == '1) state_next = IDLE;
         end
         IDLE: req_ready = 1'b1;
         default: state_next = INIT;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone select the target bytes.
   always_comb begin
      err        = 1'b0;
      byte_en    = '0;
      wdata_lane = '0;
      case (req_size)
         2'b00: begin
            byte_en    = 4'b0001 << lane;
            wdata_lane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            err        = lane[0];
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            err        = (lane != 2'b00);
            byte_en    = 4'b1111;
            wdata_lane = req_wdata;
         end
         default: err = 1'b1;
      endcase
   end

   always_comb begin
      rd_word   = mem[word_idx];
      rd_byte   = rd_word[{lane, 3'b000} +: 8];
      rd_half   = rd_word[{lane[1], 4'b0000} +: 16];
      load_data = '0;
      case (req_size)
         2'b00:   load_data = {{24{req_signed & rd_byte[7]}}, rd_byte};
         2'b01:   load_data = {{16{req_signed & rd_half[15]}}, rd_half};
         2'b10:   load_data = rd_word;
         default: load_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[init_cnt] <= '0;
         end else if (accept && req_write && !err) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         init_cnt  <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_next;
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
         rsp_valid <= accept;
         rsp_err   <= accept && err;
         rsp_rdata <= (accept && !err && !req_write) ? load_data : '0;
      end
   end

endmodule

// File: tb/tb_sized_data_memory.sv
// Self-checking bench for sized_data_memory: directed scenarios plus random
// traffic against a byte-array reference model.
module tb_sized_data_memory;

   localparam int unsigned AW    = 4;
   localparam int unsigned BAW   = AW + 2;
   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned NBYTE = 4 * DEPTH;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic           req_write;
   logic [1:0]     req_size;
   logic           req_signed;
   logic [BAW-1:0] req_addr;
   logic [31:0]    req_wdata;
   logic           rsp_valid;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;
   logic           init_busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: plain byte array plus remaining clear cycles.
   logic [7:0]  model_mem [NBYTE];
   int unsigned init_left = 0;

   sized_data_memory #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .init_busy  (init_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict, step past the edge, compare everything.
   task automatic cycle(input logic r, input logic v, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [BAW-1:0] a, input logic [31:0] wd);
      logic        exp_v, exp_e;
      logic [31:0] exp_d;
      int unsigned nb, base;
      rst = r; req_valid = v; req_write = w; req_size = sz;
      req_signed = sg; req_addr = a; req_wdata = wd;
      exp_v = 1'b0; exp_e = 1'b0; exp_d = '0;
      if (r) begin
         init_left = DEPTH;
         for (int unsigned i = 0; i < NBYTE; i++) model_mem[i] = 8'h00;
      end else if (init_left > 0) begin
         init_left--;
      end else if (v) begin
         exp_v = 1'b1;
         nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
         base = int'(a);
         if (nb == 0 || (base % nb) != 0) begin
            exp_e = 1'b1;
         end else if (w) begin
            for (int unsigned i = 0; i < nb; i++) model_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
         end else begin
            for (int unsigned i = 0; i < nb; i++) exp_d = exp_d | (32'(model_mem[base + i]) << (8 * i));
            if (sg && nb < 4 && exp_d[8*nb-1]) exp_d = exp_d | ~((32'd1 << (8 * nb)) - 1);
         end
      end
      @(posedge clk);
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      check("rsp_err",   32'(rsp_err),   32'(exp_e));
      check("rsp_rdata", rsp_rdata,      exp_d);
      check("init_busy", 32'(init_busy), 32'(init_left > 0));
      check("req_ready", 32'(req_ready), 32'(init_left == 0));
   endtask

   task automatic idle_cycles(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
   endtask

   task automatic reset_and_clear();
      int unsigned busy_cnt;
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
      busy_cnt = 0;
      for (int unsigned i = 0; i < DEPTH + 4 && init_busy; i++) begin
         busy_cnt++;
         cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
      end
      check("init_len", busy_cnt, DEPTH);
   endtask

   task automatic st(input logic [1:0] sz, input logic [BAW-1:0] a, input logic [31:0] wd);
      cycle(1'b0, 1'b1, 1'b1, sz, 1'b0, a, wd);
   endtask

   task automatic ld(input logic [1:0] sz, input logic sg, input logic [BAW-1:0] a);
      cycle(1'b0, 1'b1, 1'b0, sz, sg, a, '0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;

      cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
      reset_and_clear();

      for (int unsigned i = 0; i < DEPTH; i++) begin
         ld(2'd2, 1'b0, BAW'(4 * i));
         check("clear_word", rsp_rdata, 32'h0);
      end

      st(2'd2, 6'h08, 32'h8000_1234);
      check("store_rsp_data", rsp_rdata, 32'h0);
      ld(2'd0, 1'b1, 6'h08);
      check("ld_byte_s", rsp_rdata, 32'h0000_0034);
      ld(2'd1, 1'b1, 6'h0A);
      check("ld_half_s", rsp_rdata, 32'hFFFF_8000);
      ld(2'd1, 1'b0, 6'h0A);
      check("ld_half_u", rsp_rdata, 32'h0000_8000);

      st(2'd2, 6'h04, 32'h1111_1111);
      st(2'd0, 6'h05, 32'hFFFF_FFAB);
      ld(2'd2, 1'b0, 6'h04);
      check("byte_merge", rsp_rdata, 32'h1111_AB11);

      st(2'd1, 6'h03, 32'h0000_5555);
      check("err_half", 32'(rsp_err), 32'h1);
      ld(2'd2, 1'b0, 6'h02);
      check("err_word", 32'(rsp_err), 32'h1);
      cycle(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 6'h04, 32'h2222_2222);
      check("err_size", 32'(rsp_err), 32'h1);
      ld(2'd2, 1'b0, 6'h04);
      check("err_nowrite", rsp_rdata, 32'h1111_AB11);

      st(2'd2, 6'h0C, 32'hDEAD_BEEF);
      check("b2b_v1", 32'(rsp_valid), 32'h1);
      ld(2'd2, 1'b0, 6'h0C);
      check("b2b_v2", 32'(rsp_valid), 32'h1);
      check("b2b_data", rsp_rdata, 32'hDEAD_BEEF);

      ld(2'd2, 1'b0, 6'h0C);
      cycle(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 6'h0C, '0);
      check("rst_drop", 32'(rsp_valid), 32'h0);
      begin
         int unsigned busy_cnt;
         busy_cnt = 0;
         for (int unsigned i = 0; i < DEPTH + 4 && init_busy; i++) begin
            busy_cnt++;
            cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h0C, '0);
         end
         check("reinit_len", busy_cnt, DEPTH);
      end
      ld(2'd2, 1'b0, 6'h0C);
      check("reinit_zero", rsp_rdata, 32'h0);
      ld(2'd2, 1'b0, 6'h04);
      check("reinit_zero2", rsp_rdata, 32'h0);

      idle_cycles(3);
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
      idle_cycles(5);
      reset_and_clear();

      for (int unsigned i = 0; i < 1500; i++) begin
         logic        r, v, w, sg;
         logic [1:0]  sz;
         logic [5:0]  a;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) == 1;
         sg = $urandom_range(0, 1) == 1;
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 6'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         cycle(r, v, w, sz, sg, a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, word-address width; depth DEPTH = 2^ADDR_WIDTH words of 32 bits.
REQ-002 Parameter: BYTE_ADDR_WIDTH, fixed ADDR_WIDTH+2, byte-address width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  block accepts a request this cycle.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Port: req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 Port: req_addr  input  BYTE_ADDR_WIDTH  byte address, little-endian.
REQ-011 Port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port: rsp_valid  output  1  one-cycle response pulse.
REQ-013 Port: rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 Port: rsp_err  output  1  request was misaligned or illegal size; qualified by rsp_valid.
REQ-015 Port: init_busy  output  1  memory clear in progress.

Function
REQ-016 Two-state FSM: INIT and IDLE; INIT is entered on every rst edge.
REQ-017 INIT: ADDR_WIDTH-bit counter from 0 writes 32'h0 to one word per cycle; after writing DEPTH-1, next state IDLE; total DEPTH cycles in INIT.
REQ-018 INIT: init_busy=1, req_ready=0; req_valid ignored.
REQ-019 IDLE: init_busy=0, req_ready=1; a request is accepted on any edge where req_valid=1 in IDLE.
REQ-020 Word index = req_addr[BYTE_ADDR_WIDTH-1:2]; byte lane = req_addr[1:0].
REQ-021 Alignment: halfword requires req_addr[0]=0; word requires req_addr[1:0]=00; req_size=11 always illegal.
REQ-022 Accepted legal store: on the accept edge, only addressed lanes written (byte: 1 lane; half: lanes {addr[1],0} and {addr[1],1}; word: all 4); other lanes unchanged.
REQ-023 Accepted legal load: addressed field extracted from word and extended per req_signed (word ignores req_signed).
REQ-024 Latency: response registered; rsp_valid=1 exactly on the cycle after the accept edge, for one cycle; no backpressure on responses.
REQ-025 Error request: no memory write; response next cycle with rsp_err=1, rsp_rdata=0.
REQ-026 Store response: rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-027 Throughput: one request per cycle; back-to-back accepts yield back-to-back responses in order.
REQ-028 Store then load to same word on consecutive cycles: load returns post-store data (no stale read).
REQ-029 rsp_err and rsp_rdata are 0 whenever rsp_valid=0.

Reset
REQ-030 On rst edge: state INIT, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, init_busy=1, req_ready=0 after the edge.
REQ-031 rst asserted mid-operation (INIT or IDLE, with response pending) discards the pending response and restarts clearing from word 0.
REQ-032 Memory contents are all zero upon first entering IDLE regardless of prior contents.

Verification
REQ-033 ADDR_WIDTH=4: rst 1 cycle -> init_busy=1 for exactly 16 cycles, then req_ready=1; load word at every address -> all 32'h0.
REQ-034 Store word 0x8000_1234 to addr 0x8, then load byte addr 0x8 signed -> 0x0000_0034; load half addr 0xA signed -> 0xFFFF_8000; load half addr 0xA unsigned -> 0x0000_8000.
REQ-035 Store byte 0xAB to addr 0x5 over word 0x1111_1111 at addr 0x4 -> load word addr 0x4 returns 0x1111_AB11.
REQ-036 Store half at addr 0x3, load word at addr 0x2, req_size=11 -> each rsp_err=1, rsp_rdata=0; memory unchanged.
REQ-037 Back-to-back: store word 0xDEAD_BEEF addr 0xC in cycle N, load word addr 0xC in cycle N+1 -> rsp in N+2 = 0xDEAD_BEEF; rsp_valid high in N+1 and N+2.
REQ-038 Assert rst for 1 cycle with a load accepted the previous edge -> no rsp_valid; init_busy=1 for DEPTH cycles; previously stored data reads back 0.
